// File: rtl/qmem_pkg.sv
// ============================================================================
// Module   : qmem_pkg
// Purpose  : Shared constants, FSM encoding and helper function for the
//            multi-port QMEM slave RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qmem_pkg;

    localparam int c_ST_W = 2;

    typedef logic [c_ST_W-1:0] qmem_state_t;

    localparam qmem_state_t c_ST_IDLE = 2'd0;
    localparam qmem_state_t c_ST_WAIT = 2'd1;
    localparam qmem_state_t c_ST_RESP = 2'd2;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qmem_rr_arb.sv
// ============================================================================
// Module   : qmem_rr_arb
// Purpose  : NP-way round-robin arbiter; the search starts at ptr and wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qmem_rr_arb
    import qmem_pkg::*;
#(
    parameter int NP = 2,
    parameter int PW = (NP > 1) ? clog2(NP) : 1
) (
    input  logic [NP-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NP-1:0] gnt,
    output logic [PW-1:0] idx
);

    logic w_found;

    // First pass covers ports ptr..NP-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int j = 0; j < NP; j++) begin
            if (!w_found && req[j] && (PW'(j) >= ptr)) begin
                w_found = 1'b1;
                gnt[j]  = 1'b1;
                idx     = PW'(j);
            end
        end
        for (int j = 0; j < NP; j++) begin
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                gnt[j]  = 1'b1;
                idx     = PW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/qmem_ram_mp.sv
// ============================================================================
// Module   : qmem_ram_mp
// Purpose  : NP QMEM slave ports sharing one MS-word RAM through a round-robin
//            arbiter, with programmable read/write wait states and range errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qmem_ram_mp
    import qmem_pkg::*;
#(
    parameter int QAW       = 32,
    parameter int QDW       = 32,
    parameter int QSW       = QDW / 8,
    parameter int NP        = 2,
    parameter int MS        = 1024,
    parameter int T_RD_WAIT = 0,
    parameter int T_WR_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NP-1:0]     cs,
    input  logic [NP-1:0]     we,
    input  logic [NP*QSW-1:0] sel,
    input  logic [NP*QAW-1:0] adr,
    input  logic [NP*QDW-1:0] dat_w,
    output logic [NP*QDW-1:0] dat_r,
    output logic [NP-1:0]     ack,
    output logic [NP-1:0]     err
);

    localparam int c_PW   = (NP > 1) ? clog2(NP) : 1;
    localparam int c_SH   = clog2(QSW);
    localparam int c_AW   = (MS > 1) ? clog2(MS) : 1;
    localparam int c_MAXW = (T_RD_WAIT > T_WR_WAIT) ? T_RD_WAIT : T_WR_WAIT;
    localparam int c_CW   = (c_MAXW > 0) ? clog2(c_MAXW + 1) : 1;

    qmem_state_t       r_state;
    qmem_state_t       w_state_nxt;

    logic [c_PW-1:0]   r_idx;
    logic [c_PW-1:0]   r_ptr;
    logic [c_CW-1:0]   r_cnt;
    logic              r_we;
    logic              r_inrange;
    logic [c_AW-1:0]   r_addr;

    logic [NP-1:0]     w_arb_gnt;
    logic [c_PW-1:0]   w_arb_idx;
    logic              w_any_req;
    logic              w_req_we;
    logic [QAW-1:0]    w_req_adr;
    logic [QAW-1:0]    w_req_word;
    logic              w_req_inrange;
    logic [c_CW-1:0]   w_load;
    logic              w_gnt_cs;

    logic [QSW-1:0]    w_sel;
    logic [QDW-1:0]    w_wdat;
    logic [QDW-1:0]    w_rdat;
    logic              w_mem_wr;
    logic              w_mem_rd;
    logic [NP-1:0]     w_ack;
    logic [NP-1:0]     w_err;

    logic [QDW-1:0]    r_mem [MS];
    logic [QDW-1:0]    r_dat_r [NP];

    qmem_rr_arb #(
        .NP (NP),
        .PW (c_PW)
    ) u_arb (
        .req (cs),
        .ptr (r_ptr),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx)
    );

    // Request decode for the port the arbiter picks this cycle.
    assign w_any_req     = |cs;
    assign w_req_we      = |(we & w_arb_gnt);
    assign w_req_adr     = adr[w_arb_idx*QAW +: QAW];
    assign w_req_word    = w_req_adr >> c_SH;
    assign w_req_inrange = (w_req_word < QAW'(MS));
    assign w_load        = w_req_we ? c_CW'(T_WR_WAIT) : c_CW'(T_RD_WAIT);
    assign w_gnt_cs      = cs[r_idx];

    // Masters hold their request stable, so write data is taken live in RESP.
    assign w_sel  = sel[r_idx*QSW +: QSW];
    assign w_wdat = dat_w[r_idx*QDW +: QDW];
    assign w_rdat = r_mem[r_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = (w_load != '0) ? c_ST_WAIT : c_ST_RESP;
                end
            end
            c_ST_WAIT: begin
                if (!w_gnt_cs) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_CW'(1)) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_ack    = '0;
        w_err    = '0;
        w_mem_wr = 1'b0;
        w_mem_rd = 1'b0;
        if (r_state == c_ST_RESP) begin
            if (r_inrange) begin
                w_ack[r_idx] = 1'b1;
                w_mem_wr     = r_we;
                w_mem_rd     = !r_we;
            end else begin
                w_err[r_idx] = 1'b1;
            end
        end
    end

    // Transaction context, latched once at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_inrange <= 1'b0;
            r_addr    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_idx     <= w_arb_idx;
                        r_we      <= w_req_we;
                        r_inrange <= w_req_inrange;
                        r_addr    <= w_req_word[c_AW-1:0];
                        r_cnt     <= w_load;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                c_ST_RESP: begin
                    r_ptr <= (r_idx == c_PW'(NP - 1)) ? '0 : r_idx + c_PW'(1);
                end
                default: ;
            endcase
        end
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            for (int b = 0; b < QSW; b++) begin
                if (w_sel[b]) begin
                    r_mem[r_addr][b*8 +: 8] <= w_wdat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                r_dat_r[p] <= '0;
            end
        end else if (w_mem_rd) begin
            r_dat_r[r_idx] <= w_rdat;
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_dat_r
        assign dat_r[p*QDW +: QDW] = r_dat_r[p];
    end

    assign ack = w_ack;
    assign err = w_err;

endmodule

`default_nettype wire

// File: tb/tb_qmem_ram_mp.sv
// ============================================================================
// Module   : tb_qmem_ram_mp
// Purpose  : Directed self-checking bench for qmem_ram_mp: a zero-wait
//            instance (dut_a) and a wait-state instance (dut_b, rd 3 / wr 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qmem_ram_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cs_a, we_a, ack_a, err_a;
    logic [7:0]  sel_a;
    logic [63:0] adr_a, wd_a, rd_a;
    logic [1:0]  cs_b, we_b, ack_b, err_b;
    logic [7:0]  sel_b;
    logic [63:0] adr_b, wd_b, rd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qmem_ram_mp #(.NP(2), .MS(1024), .T_RD_WAIT(0), .T_WR_WAIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .cs(cs_a), .we(we_a), .sel(sel_a), .adr(adr_a),
        .dat_w(wd_a), .dat_r(rd_a), .ack(ack_a), .err(err_a)
    );

    qmem_ram_mp #(.NP(2), .MS(1024), .T_RD_WAIT(3), .T_WR_WAIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .cs(cs_b), .we(we_b), .sel(sel_b), .adr(adr_b),
        .dat_w(wd_b), .dat_r(rd_b), .ack(ack_b), .err(err_b)
    );

    // One bus transaction on port p; n counts edges until ack/err is seen.
    task automatic xfer(input bit use_b, input int p, input bit wr, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        output bit got_ack, output bit got_err, output int n,
                        output logic [31:0] rd);
        if (use_b) begin
            cs_b[p] = 1'b1; we_b[p] = wr; sel_b[p*4 +: 4] = s;
            adr_b[p*32 +: 32] = a; wd_b[p*32 +: 32] = d;
        end else begin
            cs_a[p] = 1'b1; we_a[p] = wr; sel_a[p*4 +: 4] = s;
            adr_a[p*32 +: 32] = a; wd_a[p*32 +: 32] = d;
        end
        n = 0; got_ack = 1'b0; got_err = 1'b0;
        while (n < 20 && !got_ack && !got_err) begin
            @(posedge clk); #1;
            n++;
            got_ack = use_b ? ack_b[p] : ack_a[p];
            got_err = use_b ? err_b[p] : err_a[p];
        end
        if (got_ack || got_err) begin
            @(posedge clk); #1;
        end
        if (use_b) cs_b[p] = 1'b0; else cs_a[p] = 1'b0;
        rd = use_b ? rd_b[p*32 +: 32] : rd_a[p*32 +: 32];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs_a = '0; we_a = '0; sel_a = '0; adr_a = '0; wd_a = '0;
        cs_b = '0; we_b = '0; sel_b = '0; adr_b = '0; wd_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", ack_a); end
        checks++; if (err_a !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", err_a); end
        checks++; if (rd_a !== 64'd0) begin errors++; $display("FAIL reset_dat_r got=%h exp=0", rd_a); end
        checks++; if ({ack_b, err_b} !== 4'b0000) begin errors++; $display("FAIL reset_b_ack_err got=%b exp=0000", {ack_b, err_b}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        bit k, e; int n; logic [31:0] r;
        xfer(0, 0, 1'b1, 4'hF, 32'h0, 32'h55AA55AA, k, e, n, r);
        checks++; if (k !== 1'b1) begin errors++; $display("FAIL wr_word0_ack got=%b exp=1", k); end
        xfer(0, 0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, k, e, n, r);
        checks++; if ({k, e} !== 2'b10) begin errors++; $display("FAIL wr0_ack_err got=%b exp=10", {k, e}); end
        checks++; if (n != 1) begin errors++; $display("FAIL wr0_latency got=%0d exp=1", n); end
        checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL ack_one_cycle got=%b exp=00", ack_a); end
        xfer(0, 1, 1'b0, 4'hF, 32'h10, 32'h0, k, e, n, r);
        checks++; if (k !== 1'b1 || n != 1) begin errors++; $display("FAIL rd1_ack got=%b/%0d exp=1/1", k, n); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd1_data got=%h exp=deadbeef", r); end
    endtask

    task automatic test_byte_write();
        bit k, e; int n; logic [31:0] r;
        xfer(0, 0, 1'b1, 4'h2, 32'h10, 32'h0000AA00, k, e, n, r);
        checks++; if (k !== 1'b1) begin errors++; $display("FAIL byte_wr_ack got=%b exp=1", k); end
        xfer(0, 1, 1'b0, 4'hF, 32'h10, 32'h0, k, e, n, r);
        checks++; if (r !== 32'hDEADAAEF) begin errors++; $display("FAIL byte_wr_data got=%h exp=deadaaef", r); end
        xfer(0, 0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, k, e, n, r);
        checks++; if (k !== 1'b1) begin errors++; $display("FAIL sel0_ack got=%b exp=1", k); end
        xfer(0, 1, 1'b0, 4'hF, 32'h10, 32'h0, k, e, n, r);
        checks++; if (r !== 32'hDEADAAEF) begin errors++; $display("FAIL sel0_data got=%h exp=deadaaef", r); end
        xfer(0, 0, 1'b0, 4'h0, 32'h13, 32'h0, k, e, n, r);
        checks++; if (r !== 32'hDEADAAEF) begin errors++; $display("FAIL low_bits_data got=%h exp=deadaaef", r); end
    endtask

    task automatic test_back_to_back();
        bit k, e; int n; logic [31:0] r;
        int idx [2];
        bit adv [2];
        int nack;
        logic [31:0] base [2];
        logic [31:0] dbase [2];
        logic [31:0] exp32;
        base[0] = 32'h20; base[1] = 32'h40;
        dbase[0] = 32'hA0000000; dbase[1] = 32'hB0000000;
        // Last preload write comes from port 1, so port 0 wins first.
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 1'b1, 4'hF, base[0] + 32'(4*i), dbase[0] + 32'(i), k, e, n, r);
            xfer(0, 1, 1'b1, 4'hF, base[1] + 32'(4*i), dbase[1] + 32'(i), k, e, n, r);
        end
        idx[0] = 0; idx[1] = 0; adv[0] = 1'b0; adv[1] = 1'b0; nack = 0;
        we_a = 2'b00; sel_a = 8'hFF;
        adr_a = {base[1], base[0]};
        cs_a = 2'b11;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (adv[p]) begin
                    exp32 = dbase[p] + 32'(idx[p]);
                    checks++;
                    if (rd_a[p*32 +: 32] !== exp32) begin
                        errors++; $display("FAIL rr_data p%0d got=%h exp=%h", p, rd_a[p*32 +: 32], exp32);
                    end
                    idx[p]++; adv[p] = 1'b0;
                    if (idx[p] == 4) cs_a[p] = 1'b0;
                    else adr_a[p*32 +: 32] = base[p] + 32'(4*idx[p]);
                end
            end
            if (ack_a != 2'b00) begin
                checks++;
                if (ack_a !== ((nack % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rr_order n%0d got=%b exp=%b", nack, ack_a, (nack % 2 == 0) ? 2'b01 : 2'b10);
                end
                for (int p = 0; p < 2; p++) if (ack_a[p]) adv[p] = 1'b1;
                nack++;
            end
        end
        checks++; if (nack != 8) begin errors++; $display("FAIL rr_count got=%0d exp=8", nack); end
        cs_a = 2'b00;
    endtask

    task automatic test_error();
        bit k, e; int n; logic [31:0] r;
        xfer(0, 1, 1'b0, 4'hF, 32'h1000, 32'h0, k, e, n, r);
        checks++; if ({k, e} !== 2'b01 || n != 1) begin errors++; $display("FAIL oor_rd got=%b/%0d exp=01/1", {k, e}, n); end
        checks++; if (r !== 32'hB0000003) begin errors++; $display("FAIL oor_rd_hold got=%h exp=b0000003", r); end
        xfer(0, 0, 1'b1, 4'hF, 32'h1000, 32'h12345678, k, e, n, r);
        checks++; if ({k, e} !== 2'b01) begin errors++; $display("FAIL oor_wr got=%b exp=01", {k, e}); end
        xfer(0, 0, 1'b0, 4'hF, 32'h0, 32'h0, k, e, n, r);
        checks++; if (r !== 32'h55AA55AA) begin errors++; $display("FAIL oor_alias_word0 got=%h exp=55aa55aa", r); end
        xfer(0, 1, 1'b0, 4'hF, 32'h10, 32'h0, k, e, n, r);
        checks++; if (r !== 32'hDEADAAEF) begin errors++; $display("FAIL oor_word4 got=%h exp=deadaaef", r); end
    endtask

    task automatic test_wait_states();
        bit k, e; int n; logic [31:0] r;
        xfer(1, 0, 1'b1, 4'hF, 32'h8, 32'hCAFEF00D, k, e, n, r);
        checks++; if (k !== 1'b1 || n != 2) begin errors++; $display("FAIL wr_wait1 got=%b/%0d exp=1/2", k, n); end
        xfer(1, 0, 1'b0, 4'hF, 32'h8, 32'h0, k, e, n, r);
        checks++; if (k !== 1'b1 || n != 4) begin errors++; $display("FAIL rd_wait3 got=%b/%0d exp=1/4", k, n); end
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_wait3_data got=%h exp=cafef00d", r); end
    endtask

    task automatic test_cs_abort();
        bit k, e, seen; int n; logic [31:0] r;
        cs_b[0] = 1'b1; we_b[0] = 1'b1; sel_b[3:0] = 4'hF;
        adr_b[31:0] = 32'h8; wd_b[31:0] = 32'h22222222;
        @(posedge clk); #1;
        cs_b[0] = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack_b != 2'b00 || err_b != 2'b00) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_resp got=%b exp=0", seen); end
        xfer(1, 0, 1'b0, 4'hF, 32'h8, 32'h0, k, e, n, r);
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_no_write got=%h exp=cafef00d", r); end
    endtask

    task automatic test_reset_abort();
        bit k, e; int n; logic [31:0] r;
        cs_b[0] = 1'b1; we_b[0] = 1'b1; sel_b[3:0] = 4'hF;
        adr_b[31:0] = 32'h8; wd_b[31:0] = 32'h33333333;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({ack_b, err_b} !== 4'b0000) begin errors++; $display("FAIL rst_wait_ack_err got=%b exp=0000", {ack_b, err_b}); end
        checks++; if (rd_b !== 64'd0) begin errors++; $display("FAIL rst_wait_dat_r got=%h exp=0", rd_b); end
        cs_b[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 0, 1'b0, 4'hF, 32'h8, 32'h0, k, e, n, r);
        checks++; if (k !== 1'b1 || n != 4) begin errors++; $display("FAIL rst_recover got=%b/%0d exp=1/4", k, n); end
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_no_write got=%h exp=cafef00d", r); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_error();
        test_wait_states();
        test_cs_abort();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

`default_nettype wire
